// File: rtl/axis_traffic_gen_chk_if.sv
// AXI-Stream bundle shared by the traffic generator/checker ports.
// Lane 0 sits in the most significant byte of tdata, with its keep bit at tkeep MSB.
interface axis_traffic_gen_chk_if #(
    parameter int DWIDTH = 128
);
    logic [DWIDTH-1:0]   tdata;
    logic [DWIDTH/8-1:0] tkeep;
    logic                tlast;
    logic                tvalid;
    logic                tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_traffic_gen_chk.sv
// AXI-Stream traffic generator plus loopback self-checker.
// The generator emits packets whose lengths step from MIN_PKT_BYTES up to
// MAX_PKT_BYTES and then wrap. Lane j of each beat carries (S + j) mod 256,
// where S is the running stream byte count. The checker regenerates the same
// sequence, counts mismatching beats, and reports a verdict once the return
// path has been idle for long enough.
// Optional macro TRAFFIC_BACKPRESSURE_EN: an LFSR inserts tx bubbles and drops
// rx ready.

// Produces the expected byte and keep bit for one lane, given the beat's byte
// base and the number of valid lanes.
module axis_tgc_lane #(
    parameter int LANE = 0,
    parameter int LW   = 5
) (
    input  logic [7:0]    base,
    input  logic [LW-1:0] nlanes,
    output logic [7:0]    exp_byte,
    output logic          exp_keep
);
    localparam logic [LW-1:0] IDX = LW'(LANE);
    localparam logic [7:0]    OFS = 8'(LANE);

    // valid lanes are contiguous from lane 0; invalid lanes read as zero
    always_comb begin
        exp_keep = (IDX < nlanes);
        exp_byte = exp_keep ? (base + OFS) : 8'h00;
    end
endmodule

module axis_traffic_gen_chk #(
    parameter int DWIDTH        = 128,
    parameter int NUM_PKTS      = 16,
    parameter int MIN_PKT_BYTES = 1,
    parameter int MAX_PKT_BYTES = 256,
    parameter int IDLE_TIMEOUT  = 500
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    axis_traffic_gen_chk_if.master m_axis,
    axis_traffic_gen_chk_if.slave  s_axis,
    output logic                   send_done,
    output logic [31:0]            tx_pkt_cnt,
    output logic [31:0]            rx_pkt_cnt,
    output logic [15:0]            err_cnt,
    output logic                   check_result,
    output logic                   check_result_valid
);
    localparam int          B    = DWIDTH / 8;
    localparam int          LW   = $clog2(B + 1);
    localparam logic [31:0] BW   = 32'(B);
    localparam logic [LW-1:0] BN = LW'(B);
    localparam logic [31:0] NPK  = 32'(NUM_PKTS);
    localparam logic [31:0] MINL = 32'(MIN_PKT_BYTES);
    localparam logic [31:0] MAXL = 32'(MAX_PKT_BYTES);
    localparam logic [31:0] TOL  = 32'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {G_IDLE, G_SEND, G_DONE} gen_st_t;
    typedef enum logic [1:0] {C_IDLE, C_CHECK, C_VERDICT} chk_st_t;

    function automatic logic [31:0] next_len(input logic [31:0] l);
        return (l >= MAXL) ? MINL : l + 32'd1;
    endfunction

    // ---------------------------------------------------------------- pacing
    logic bubble;
    logic rx_gate;

`ifdef TRAFFIC_BACKPRESSURE_EN
    logic [15:0] lfsr;

    // free-running Fibonacci LFSR, x^16+x^14+x^13+x^11+1
    always_ff @(posedge clk) begin
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign bubble  = (lfsr[3:2] == 2'b00);
    assign rx_gate = (lfsr[1:0] != 2'b00);
`else
    assign bubble  = 1'b0;
    assign rx_gate = 1'b1;
`endif

    // ------------------------------------------------------------ generator
    gen_st_t            g_state, g_next;
    logic [31:0]        g_len_q, g_rem_q, g_issued_q;
    logic [7:0]         g_base_q;
    logic [31:0]        src_len, src_rem, src_issued;
    logic [7:0]         src_base;
    logic               beat_last, more, load, m_hs;
    logic [LW-1:0]      beat_n;
    logic [B-1:0][7:0]  g_lane;
    logic [B-1:0]       g_keep;
    logic [DWIDTH-1:0]  m_tdata_q;
    logic [B-1:0]       m_tkeep_q;
    logic               m_tlast_q, m_tvalid_q;
    logic [31:0]        tx_cnt_q;

    // a start from IDLE restarts the length/byte sequence, so the first beat
    // can be built in the same cycle that start is seen
    always_comb begin
        src_len    = g_len_q;
        src_rem    = g_rem_q;
        src_base   = g_base_q;
        src_issued = g_issued_q;
        if (g_state == G_IDLE) begin
            src_len    = MINL;
            src_rem    = MINL;
            src_base   = 8'h00;
            src_issued = 32'd0;
        end
        beat_last = (src_rem <= BW);
        beat_n    = beat_last ? LW'(src_rem) : BN;
        more      = (NPK == 32'd0) || (src_issued < NPK);
        m_hs      = m_tvalid_q && m_axis.tready;
        load      = ((g_state == G_SEND) || (g_state == G_IDLE && start)) &&
                    (!m_tvalid_q || m_axis.tready) && more && !bubble;
    end

    for (genvar j = 0; j < B; j++) begin : g_gen_lane
        axis_tgc_lane #(.LANE(j), .LW(LW)) u_lane (
            .base     (src_base),
            .nlanes   (beat_n),
            .exp_byte (g_lane[B-1-j]),
            .exp_keep (g_keep[B-1-j])
        );
    end

    // generator state register
    always_ff @(posedge clk) begin
        if (rst) g_state <= G_IDLE;
        else     g_state <= g_next;
    end

    // generator next state: finish once the last packet's tlast is accepted
    always_comb begin
        g_next = g_state;
        case (g_state)
            G_IDLE:  if (start) g_next = G_SEND;
            G_SEND:  if (m_hs && m_tlast_q && (NPK != 32'd0) &&
                         (tx_cnt_q == NPK - 32'd1)) g_next = G_DONE;
            default: g_next = g_state;
        endcase
    end

    // generator outputs
    always_comb begin
        send_done = (g_state == G_DONE);
    end

    // sequence state and the output beat register; a presented beat is held
    // until accepted, and the next one is loaded on the accepting edge
    always_ff @(posedge clk) begin
        if (rst) begin
            g_len_q    <= 32'd0;
            g_rem_q    <= 32'd0;
            g_issued_q <= 32'd0;
            g_base_q   <= 8'h00;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
            tx_cnt_q   <= 32'd0;
        end else begin
            if (g_state == G_IDLE && start) begin
                g_len_q    <= MINL;
                g_rem_q    <= MINL;
                g_issued_q <= 32'd0;
                g_base_q   <= 8'h00;
            end
            if (load) begin
                m_tdata_q  <= g_lane;
                m_tkeep_q  <= g_keep;
                m_tlast_q  <= beat_last;
                m_tvalid_q <= 1'b1;
                g_base_q   <= src_base + 8'(beat_n);
                if (beat_last) begin
                    g_len_q    <= next_len(src_len);
                    g_rem_q    <= next_len(src_len);
                    g_issued_q <= src_issued + 32'd1;
                end else begin
                    g_rem_q    <= src_rem - BW;
                end
            end else if (m_hs) begin
                m_tvalid_q <= 1'b0;
                m_tdata_q  <= '0;
                m_tkeep_q  <= '0;
                m_tlast_q  <= 1'b0;
            end
            if (m_hs && m_tlast_q) tx_cnt_q <= tx_cnt_q + 32'd1;
        end
    end

    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tkeep  = m_tkeep_q;
    assign m_axis.tlast  = m_tlast_q;
    assign m_axis.tvalid = m_tvalid_q;
    assign tx_pkt_cnt    = tx_cnt_q;

    // -------------------------------------------------------------- checker
    chk_st_t            c_state, c_next;
    logic [31:0]        c_len_q, c_off_q, idle_q, rx_cnt_q;
    logic [7:0]         c_pkt_base_q;
    logic [15:0]        err_q;
    logic               s_rdy_q;
    logic [31:0]        c_rem;
    logic               c_ended, c_last, c_hs, c_err;
    logic [LW-1:0]      c_n;
    logic [7:0]         c_base;
    logic [B-1:0][7:0]  c_lane, s_lane;
    logic [B-1:0]       c_keep, byte_bad;

    // expected beat: position within the current expected packet
    always_comb begin
        c_ended = (c_off_q >= c_len_q);
        c_rem   = c_ended ? 32'd0 : (c_len_q - c_off_q);
        c_last  = (c_rem <= BW);
        c_n     = c_last ? LW'(c_rem) : BN;
        c_base  = c_pkt_base_q + c_off_q[7:0];
        s_lane  = s_axis.tdata;
        c_hs    = (c_state == C_CHECK) && s_axis.tvalid && s_axis.tready;
        c_err   = (s_axis.tkeep != c_keep) || (|byte_bad) ||
                  (s_axis.tlast != c_last) || c_ended;
    end

    for (genvar j = 0; j < B; j++) begin : g_chk_lane
        axis_tgc_lane #(.LANE(j), .LW(LW)) u_lane (
            .base     (c_base),
            .nlanes   (c_n),
            .exp_byte (c_lane[B-1-j]),
            .exp_keep (c_keep[B-1-j])
        );
        // bytes under a deasserted keep bit are don't-care
        assign byte_bad[B-1-j] = s_axis.tkeep[B-1-j] && (s_lane[B-1-j] != c_lane[B-1-j]);
    end

    // checker state register
    always_ff @(posedge clk) begin
        if (rst) c_state <= C_IDLE;
        else     c_state <= c_next;
    end

    // checker next state: verdict after the return path has gone quiet
    always_comb begin
        c_next = c_state;
        case (c_state)
            C_IDLE:  if (start) c_next = C_CHECK;
            C_CHECK: if (send_done && !s_axis.tvalid && (idle_q == TOL)) c_next = C_VERDICT;
            default: c_next = c_state;
        endcase
    end

    // checker outputs; counters are frozen in VERDICT so the verdict holds
    always_comb begin
        check_result_valid = (c_state == C_VERDICT);
        check_result       = check_result_valid && (err_q == 16'd0) && (rx_cnt_q == NPK);
    end

    // compare accepted beats; a received tlast resyncs to the next expected
    // packet, advancing the byte base by the expected length
    always_ff @(posedge clk) begin
        if (rst) begin
            c_len_q      <= 32'd0;
            c_off_q      <= 32'd0;
            c_pkt_base_q <= 8'h00;
            idle_q       <= 32'd0;
            rx_cnt_q     <= 32'd0;
            err_q        <= 16'd0;
            s_rdy_q      <= 1'b0;
        end else begin
            s_rdy_q <= 1'b1;
            if (c_state == C_IDLE && start) begin
                c_len_q      <= MINL;
                c_off_q      <= 32'd0;
                c_pkt_base_q <= 8'h00;
                idle_q       <= 32'd0;
            end
            if (c_state == C_CHECK) begin
                if (s_axis.tvalid)                        idle_q <= 32'd0;
                else if (send_done && idle_q != TOL)      idle_q <= idle_q + 32'd1;
            end
            if (c_hs) begin
                if (c_err && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
                if (s_axis.tlast) begin
                    rx_cnt_q     <= rx_cnt_q + 32'd1;
                    c_pkt_base_q <= c_pkt_base_q + c_len_q[7:0];
                    c_len_q      <= next_len(c_len_q);
                    c_off_q      <= 32'd0;
                end else begin
                    c_off_q <= c_off_q + 32'(c_n);
                end
            end
        end
    end

    assign s_axis.tready = s_rdy_q && rx_gate;
    assign rx_pkt_cnt    = rx_cnt_q;
    assign err_cnt       = err_q;
endmodule

// File: tb/tb_axis_traffic_gen_chk.sv
// Bench for axis_traffic_gen_chk: loops m_axis back into s_axis, with knobs for
// corruption, tx backpressure and a dead return path. Expected beats come from
// a small reference model of the packet sequence.
module tb_axis_traffic_gen_chk;
    localparam int DW  = 128;
    localparam int KB  = DW / 8;
    localparam int NP  = 20;
    localparam int MIN = 1;
    localparam int MAX = 18;
    localparam int TO  = 20;
    localparam logic [DW-1:0] CMASK = {{7{1'b0}}, 1'b1, {(DW-8){1'b0}}};

    typedef struct {
        logic [DW-1:0] d;
        logic [KB-1:0] k;
        logic          l;
    } beat_t;

    logic        clk, rst, start;
    logic        send_done, check_result, check_result_valid;
    logic [31:0] tx_pkt_cnt, rx_pkt_cnt;
    logic [15:0] err_cnt;
    logic        tb_rdy, loop_en;
    int          corrupt_beat;
    int          m_beat;
    int          pass_cnt = 0;
    int          chk_cnt  = 0;
    beat_t       exp_q[$];
    beat_t       cap_q[$];
    beat_t       mon_b;

    axis_traffic_gen_chk_if #(.DWIDTH(DW)) m_if ();
    axis_traffic_gen_chk_if #(.DWIDTH(DW)) s_if ();

    axis_traffic_gen_chk #(
        .DWIDTH(DW), .NUM_PKTS(NP), .MIN_PKT_BYTES(MIN),
        .MAX_PKT_BYTES(MAX), .IDLE_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .m_axis(m_if), .s_axis(s_if),
        .send_done(send_done), .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt),
        .err_cnt(err_cnt), .check_result(check_result),
        .check_result_valid(check_result_valid)
    );

    // loopback path
    assign m_if.tready = tb_rdy && s_if.tready;
    assign s_if.tvalid = m_if.tvalid && tb_rdy && loop_en;
    assign s_if.tdata  = m_if.tdata ^ ((m_beat == corrupt_beat) ? CMASK : '0);
    assign s_if.tkeep  = m_if.tkeep;
    assign s_if.tlast  = m_if.tlast;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // count accepted tx beats since reset
    always @(posedge clk) begin
        if (rst) m_beat <= 0;
        else if (m_if.tvalid && m_if.tready) m_beat <= m_beat + 1;
    end

    // capture accepted tx beats mid-cycle
    always @(negedge clk) begin
        if (!rst && m_if.tvalid && m_if.tready) begin
            mon_b.d = m_if.tdata;
            mon_b.k = m_if.tkeep;
            mon_b.l = m_if.tlast;
            cap_q.push_back(mon_b);
        end
    end

    // reference model of the whole run
    task automatic build_exp(input int npk);
        int s, len, rem, n;
        beat_t b;
        s = 0;
        len = MIN;
        for (int p = 0; p < npk; p++) begin
            rem = len;
            while (rem > 0) begin
                n = (rem > KB) ? KB : rem;
                b.d = '0;
                b.k = '0;
                for (int j = 0; j < n; j++) begin
                    b.d[DW-1-8*j -: 8] = 8'((s + j) % 256);
                    b.k[KB-1-j] = 1'b1;
                end
                b.l = (rem <= KB);
                exp_q.push_back(b);
                s += n;
                rem -= n;
            end
            len = (len == MAX) ? MIN : len + 1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_verdict(input int max_cyc, output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (check_result_valid) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        chk_cnt++;
        if ({m_if.tvalid, m_if.tlast, send_done, check_result, check_result_valid} !== 5'b0)
            $display("FAIL reset_flags got %b want 00000",
                     {m_if.tvalid, m_if.tlast, send_done, check_result, check_result_valid});
        else pass_cnt++;
        chk_cnt++;
        if (m_if.tdata !== '0 || m_if.tkeep !== '0)
            $display("FAIL reset_bus got %h/%h want 0/0", m_if.tdata, m_if.tkeep);
        else pass_cnt++;
        chk_cnt++;
        if (tx_pkt_cnt !== 32'd0 || rx_pkt_cnt !== 32'd0 || err_cnt !== 16'd0)
            $display("FAIL reset_cnts got %0d/%0d/%0d want 0/0/0", tx_pkt_cnt, rx_pkt_cnt, err_cnt);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (s_if.tready !== 1'b1) $display("FAIL reset_tready got %b want 1", s_if.tready);
        else pass_cnt++;
    endtask

    task automatic test_sweep();
        bit to;
        beat_t e, c;
        int i;
        do_reset();
        build_exp(NP);
        pulse_start();
        wait_verdict(2000, to);
        chk_cnt++;
        if (to) $display("FAIL sweep_verdict got timeout want verdict");
        else pass_cnt++;
        chk_cnt++;
        if (cap_q.size() !== exp_q.size())
            $display("FAIL sweep_nbeats got %0d want %0d", cap_q.size(), exp_q.size());
        else pass_cnt++;
        chk_cnt++;
        if (cap_q.size() < 21)
            $display("FAIL sweep_spot got %0d beats want 22", cap_q.size());
        else if (cap_q[0].k !== 16'h8000 || cap_q[1].k !== 16'hC000 ||
                 cap_q[2].k !== 16'hE000 || cap_q[3].k !== 16'hF000 ||
                 cap_q[0].d[DW-1 -: 8] !== 8'h00 || cap_q[1].d[DW-1 -: 8] !== 8'h01 ||
                 cap_q[2].d[DW-1 -: 8] !== 8'h03 || cap_q[3].d[DW-1 -: 8] !== 8'h06)
            $display("FAIL sweep_spot got keep %h %h %h %h lane0 %h %h %h %h",
                     cap_q[0].k, cap_q[1].k, cap_q[2].k, cap_q[3].k, cap_q[0].d[DW-1 -: 8],
                     cap_q[1].d[DW-1 -: 8], cap_q[2].d[DW-1 -: 8], cap_q[3].d[DW-1 -: 8]);
        else pass_cnt++;
        chk_cnt++;
        if (cap_q.size() < 21)
            $display("FAIL multibeat_spot got %0d beats want 22", cap_q.size());
        else if (cap_q[17].k !== 16'h8000 || cap_q[17].l !== 1'b1 || cap_q[16].l !== 1'b0 ||
                 cap_q[17].d[DW-1 -: 8] !== 8'h98 || cap_q[18].d[DW-1 -: 8] !== 8'h99 ||
                 cap_q[19].k !== 16'hC000 || cap_q[20].k !== 16'h8000)
            $display("FAIL multibeat_spot got keep %h %h %h lane0 %h %h",
                     cap_q[17].k, cap_q[19].k, cap_q[20].k,
                     cap_q[17].d[DW-1 -: 8], cap_q[18].d[DW-1 -: 8]);
        else pass_cnt++;
        i = 0;
        while (exp_q.size() > 0 && cap_q.size() > 0) begin
            e = exp_q.pop_front();
            c = cap_q.pop_front();
            chk_cnt++;
            if (c.d !== e.d || c.k !== e.k || c.l !== e.l)
                $display("FAIL sweep_beat%0d got %h/%h/%b want %h/%h/%b", i, c.d, c.k, c.l, e.d, e.k, e.l);
            else pass_cnt++;
            i++;
        end
        chk_cnt++;
        if (check_result !== 1'b1 || rx_pkt_cnt !== 32'(NP) || tx_pkt_cnt !== 32'(NP) ||
            err_cnt !== 16'd0 || send_done !== 1'b1)
            $display("FAIL sweep_result got res %b rx %0d tx %0d err %0d done %b want 1 %0d %0d 0 1",
                     check_result, rx_pkt_cnt, tx_pkt_cnt, err_cnt, send_done, NP, NP);
        else pass_cnt++;
    endtask

    task automatic test_corrupt();
        bit to;
        beat_t e, c;
        int i;
        do_reset();
        corrupt_beat = 2;
        build_exp(NP);
        pulse_start();
        wait_verdict(2000, to);
        corrupt_beat = -1;
        chk_cnt++;
        if (to) $display("FAIL corrupt_verdict got timeout want verdict");
        else pass_cnt++;
        i = 0;
        while (exp_q.size() > 0 && cap_q.size() > 0) begin
            e = exp_q.pop_front();
            c = cap_q.pop_front();
            chk_cnt++;
            if (c.d !== e.d || c.k !== e.k || c.l !== e.l)
                $display("FAIL corrupt_beat%0d got %h/%h/%b want %h/%h/%b", i, c.d, c.k, c.l, e.d, e.k, e.l);
            else pass_cnt++;
            i++;
        end
        chk_cnt++;
        if (err_cnt !== 16'd1 || rx_pkt_cnt !== 32'(NP) || check_result !== 1'b0)
            $display("FAIL corrupt_result got err %0d rx %0d res %b want 1 %0d 0",
                     err_cnt, rx_pkt_cnt, check_result, NP);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bit to, seen;
        beat_t e, c, h;
        int i;
        do_reset();
        build_exp(NP);
        h = exp_q[17];
        pulse_start();
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (m_beat == 17) begin
                seen = 1'b1;
                break;
            end
        end
        chk_cnt++;
        if (!seen) $display("FAIL hold_reach got beat %0d want 17", m_beat);
        else pass_cnt++;
        tb_rdy = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk_cnt++;
            if (m_if.tvalid !== 1'b1 || m_if.tdata !== h.d || m_if.tkeep !== h.k || m_if.tlast !== h.l)
                $display("FAIL hold_cyc%0d got %b/%h/%h/%b want 1/%h/%h/%b", k,
                         m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast, h.d, h.k, h.l);
            else pass_cnt++;
        end
        @(posedge clk); #1;
        tb_rdy = 1'b1;
        wait_verdict(2000, to);
        chk_cnt++;
        if (to) $display("FAIL hold_verdict got timeout want verdict");
        else pass_cnt++;
        chk_cnt++;
        if (cap_q.size() !== exp_q.size())
            $display("FAIL hold_nbeats got %0d want %0d", cap_q.size(), exp_q.size());
        else pass_cnt++;
        i = 0;
        while (exp_q.size() > 0 && cap_q.size() > 0) begin
            e = exp_q.pop_front();
            c = cap_q.pop_front();
            chk_cnt++;
            if (c.d !== e.d || c.k !== e.k || c.l !== e.l)
                $display("FAIL hold_beat%0d got %h/%h/%b want %h/%h/%b", i, c.d, c.k, c.l, e.d, e.k, e.l);
            else pass_cnt++;
            i++;
        end
        chk_cnt++;
        if (check_result !== 1'b1 || err_cnt !== 16'd0)
            $display("FAIL hold_result got res %b err %0d want 1 0", check_result, err_cnt);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        bit seen;
        int n;
        do_reset();
        loop_en = 1'b0;
        pulse_start();
        seen = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (send_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk_cnt++;
        if (!seen) $display("FAIL timeout_send_done got 0 want 1");
        else pass_cnt++;
        n = 0;
        seen = 1'b0;
        for (int k = 0; k < 10 * TO + 50; k++) begin
            @(negedge clk);
            n++;
            if (check_result_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk_cnt++;
        if (!seen || n !== TO + 1)
            $display("FAIL timeout_latency got %0d (seen %b) want %0d", n, seen, TO + 1);
        else pass_cnt++;
        chk_cnt++;
        if (check_result !== 1'b0 || rx_pkt_cnt !== 32'd0 || tx_pkt_cnt !== 32'(NP))
            $display("FAIL timeout_result got res %b rx %0d tx %0d want 0 0 %0d",
                     check_result, rx_pkt_cnt, tx_pkt_cnt, NP);
        else pass_cnt++;
        loop_en = 1'b1;
    endtask

    task automatic test_reset_midrun();
        bit to, seen;
        beat_t e, c;
        int i;
        do_reset();
        pulse_start();
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (m_beat == 1) begin
                seen = 1'b1;
                break;
            end
        end
        chk_cnt++;
        if (!seen) $display("FAIL midrst_reach got beat %0d want 1", m_beat);
        else pass_cnt++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (m_if.tvalid !== 1'b0 || tx_pkt_cnt !== 32'd0 || rx_pkt_cnt !== 32'd0 ||
            err_cnt !== 16'd0 || send_done !== 1'b0)
            $display("FAIL midrst_state got v %b tx %0d rx %0d err %0d done %b want 0 0 0 0 0",
                     m_if.tvalid, tx_pkt_cnt, rx_pkt_cnt, err_cnt, send_done);
        else pass_cnt++;
        cap_q.delete();
        exp_q.delete();
        build_exp(NP);
        pulse_start();
        wait_verdict(2000, to);
        chk_cnt++;
        if (to) $display("FAIL midrst_verdict got timeout want verdict");
        else pass_cnt++;
        chk_cnt++;
        if (cap_q.size() < 1)
            $display("FAIL midrst_first got no beats want 1");
        else if (cap_q[0].k !== 16'h8000 || cap_q[0].d[DW-1 -: 8] !== 8'h00)
            $display("FAIL midrst_first got %h/%h want 8000/00", cap_q[0].k, cap_q[0].d[DW-1 -: 8]);
        else pass_cnt++;
        i = 0;
        while (exp_q.size() > 0 && cap_q.size() > 0) begin
            e = exp_q.pop_front();
            c = cap_q.pop_front();
            chk_cnt++;
            if (c.d !== e.d || c.k !== e.k || c.l !== e.l)
                $display("FAIL midrst_beat%0d got %h/%h/%b want %h/%h/%b", i, c.d, c.k, c.l, e.d, e.k, e.l);
            else pass_cnt++;
            i++;
        end
        chk_cnt++;
        if (check_result !== 1'b1 || rx_pkt_cnt !== 32'(NP) || err_cnt !== 16'd0)
            $display("FAIL midrst_result got res %b rx %0d err %0d want 1 %0d 0",
                     check_result, rx_pkt_cnt, err_cnt, NP);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        tb_rdy = 1'b1;
        loop_en = 1'b1;
        corrupt_beat = -1;
        test_reset();
        test_sweep();
        test_corrupt();
        test_backpressure();
        test_timeout();
        test_reset_midrun();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
